mult_div_unit: RTL and testbench



---
 rtl/rv32i_types.sv | 22 ++
 rtl/radix2_divider.sv | 85 ++++++++
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the multiply/divide unit: operation encoding and controller states.
package rv32i_types;

  typedef enum logic [2:0] {
    MOP_MUL    = 3'd0,
    MOP_MULH   = 3'd1,
    MOP_MULHSU = 3'd2,
    MOP_MULHU  = 3'd3,
    MOP_DIV    = 3'd4,
    MOP_DIVU   = 3'd5,
    MOP_REM    = 3'd6,
    MOP_REMU   = 3'd7
  } mult_ops;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/radix2_divider.sv
// Unsigned radix-2 restoring divider; one quotient bit per cycle, first bit taken on the start edge.
module radix2_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [XLEN-1:0]  src_rem, src_quo, src_dvs, rem_step, quo_step;
  logic [XLEN:0]    shifted, diff;
  logic             take;

  // Start feeds the step logic directly so the load edge already resolves the top quotient bit.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dvs  = start ? divisor : dvs_q;
    shifted  = {src_rem, src_quo[XLEN-1]};
    diff     = shifted - {1'b0, src_dvs};
    take     = ~diff[XLEN];
    rem_step = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_step = {src_quo[XLEN-2:0], take};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = rem_step;
      quo_d  = quo_step;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(XLEN - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Single-issue M-extension unit: pipelined multiply, iterative divide, one-cycle CDB broadcast.
// state | meaning
// IDLE  | ready for an issue
// MUL   | product registered, waiting out the multiply latency
// DIV   | divider iterating on operand magnitudes
// DONE  | result broadcast on the mul lane for one cycle
module mult_div_unit
  import rv32i_types::*;
#(
  parameter int XLEN          = 32,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int MUL_LAT       = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  mult_ops                  issue_multop,
  input  logic [XLEN-1:0]          issue_rs1_data,
  input  logic [XLEN-1:0]          issue_rs2_data,
  input  logic [4:0]               issue_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0] issue_rd_rob_idx,
  output logic                     issue_ready,
  output logic                     mul_valid,
  output logic [XLEN-1:0]          mul_data,
  output logic [4:0]               mul_rd_addr,
  output logic [ROB_IDX_WIDTH-1:0] mul_rob_idx
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 2);

  mdu_state_t               state_q, state_d;
  mult_ops                  op_q, op_d;
  logic [4:0]               rd_q, rd_d;
  logic [ROB_IDX_WIDTH-1:0] rob_q, rob_d;
  logic [2*XLEN-1:0]        prod_q, prod_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [XLEN-1:0]          result_q, result_d;

  logic              accept, issue_is_div, issue_is_rem, signed_div;
  logic              a_neg, b_neg, a_sx, b_sx, div_by_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*XLEN-1:0] a_ext, b_ext, prod_full;
  logic              div_start, div_busy, div_done;
  logic [XLEN-1:0]   div_quotient, div_remainder;

  assign issue_ready = (state_q == IDLE);
  assign accept      = issue_valid && issue_ready && !flush;

  always_comb begin
    issue_is_div = issue_multop inside {MOP_DIV, MOP_DIVU, MOP_REM, MOP_REMU};
    issue_is_rem = issue_multop inside {MOP_REM, MOP_REMU};
    signed_div   = issue_multop inside {MOP_DIV, MOP_REM};
    a_neg        = signed_div && issue_rs1_data[XLEN-1];
    b_neg        = signed_div && issue_rs2_data[XLEN-1];
    a_mag        = a_neg ? -issue_rs1_data : issue_rs1_data;
    b_mag        = b_neg ? -issue_rs2_data : issue_rs2_data;
    div_by_zero  = (issue_rs2_data == '0);
    div_ovf      = signed_div && (issue_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (issue_rs2_data == '1);
    // Sign-extending to the full product width makes one unsigned multiply cover all signedness mixes.
    a_sx         = (issue_multop == MOP_MULH || issue_multop == MOP_MULHSU) && issue_rs1_data[XLEN-1];
    b_sx         = (issue_multop == MOP_MULH) && issue_rs2_data[XLEN-1];
    a_ext        = {{XLEN{a_sx}}, issue_rs1_data};
    b_ext        = {{XLEN{b_sx}}, issue_rs2_data};
    prod_full    = a_ext * b_ext;
    quo_fix      = q_neg_q ? -div_quotient : div_quotient;
    rem_fix      = r_neg_q ? -div_remainder : div_remainder;
  end

  radix2_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst_n     (rst),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rob_d     = rob_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = issue_multop;
          rd_d  = issue_rd_addr;
          rob_d = issue_rd_rob_idx;
          if (!issue_is_div) begin
            prod_d  = prod_full;
            cnt_d   = MUL_CNT_INIT;
            state_d = MUL;
          end else if (div_by_zero) begin
            result_d = issue_is_rem ? issue_rs1_data : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = issue_is_rem ? '0 : issue_rs1_data;
            state_d  = DONE;
          end else begin
            div_start = 1'b1;
            q_neg_d   = a_neg ^ b_neg;
            r_neg_d   = a_neg;
            state_d   = DIV;
          end
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          result_d = (op_q == MOP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV: begin
        if (div_done) begin
          result_d = (op_q inside {MOP_REM, MOP_REMU}) ? rem_fix : quo_fix;
          state_d  = DONE;
        end else if (!div_busy) begin
          // Divider lost its operation (never expected); drop back rather than hang.
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= MOP_MUL;
      rd_q     <= '0;
      rob_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rob_q    <= rob_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign mul_valid   = (state_q == DONE) && !flush;
  assign mul_data    = mul_valid ? result_q : '0;
  assign mul_rd_addr = mul_valid ? rd_q : '0;
  assign mul_rob_idx = mul_valid ? rob_q : '0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle plus directed vectors.
module tb_mult_div_unit;
  import rv32i_types::*;

  localparam int XLEN    = 32;
  localparam int RW      = 5;
  localparam int MUL_LAT = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            issue_valid = 1'b0;
  mult_ops         issue_multop = MOP_MUL;
  logic [XLEN-1:0] rs1 = '0, rs2 = '0;
  logic [4:0]      rd = '0;
  logic [RW-1:0]   rob = '0;
  logic            issue_ready, mul_valid;
  logic [XLEN-1:0] mul_data;
  logic [4:0]      mul_rd_addr;
  logic [RW-1:0]   mul_rob_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  mult_div_unit #(.XLEN(XLEN), .ROB_IDX_WIDTH(RW), .MUL_LAT(MUL_LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .issue_valid      (issue_valid),
    .issue_multop     (issue_multop),
    .issue_rs1_data   (rs1),
    .issue_rs2_data   (rs2),
    .issue_rd_addr    (rd),
    .issue_rd_rob_idx (rob),
    .issue_ready      (issue_ready),
    .mul_valid        (mul_valid),
    .mul_data         (mul_data),
    .mul_rd_addr      (mul_rd_addr),
    .mul_rob_idx      (mul_rob_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(mult_ops op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = '0;
    case (op)
      MOP_MUL:    begin p = sa * sb; return p[31:0]; end
      MOP_MULH:   begin p = sa * sb; return p[63:32]; end
      MOP_MULHSU: begin p = sa * longint'(ua); return p[63:32]; end
      MOP_MULHU:  begin p = ua * ub; return p[63:32]; end
      MOP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb;
        return p[31:0];
      end
      MOP_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      MOP_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub;
        return p[31:0];
      end
      MOP_REMU: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(mult_ops op, logic [31:0] a, logic [31:0] b);
    if (op inside {MOP_MUL, MOP_MULH, MOP_MULHSU, MOP_MULHU}) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == MOP_DIV || op == MOP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Cycle model: one outstanding op, result due in the window ref_lat windows after the issue window.
  logic          pend = 1'b0;
  int            pend_edge = 0;
  logic [31:0]   pend_data = '0;
  logic [4:0]    pend_rd = '0;
  logic [RW-1:0] pend_rob = '0;
  logic          exp_ready, exp_valid;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pend = 1'b0;
        chk("m_rst_valid", mul_valid, 0);
        chk("m_rst_data", mul_data, 0);
        chk("m_rst_rd", mul_rd_addr, 0);
        chk("m_rst_rob", mul_rob_idx, 0);
      end else begin
        exp_ready = !(pend && ecount <= pend_edge);
        exp_valid = pend && (ecount == pend_edge) && !flush;
        chk("m_ready", issue_ready, exp_ready);
        chk("m_valid", mul_valid, exp_valid);
        chk("m_data", mul_data, exp_valid ? pend_data : 32'h0);
        chk("m_rd", mul_rd_addr, exp_valid ? pend_rd : 5'h0);
        chk("m_rob", mul_rob_idx, exp_valid ? pend_rob : '0);
        if (flush) pend = 1'b0;
        else if (pend && ecount == pend_edge) pend = 1'b0;
        if (issue_valid && exp_ready && !flush) begin
          pend      = 1'b1;
          pend_data = ref_result(issue_multop, rs1, rs2);
          pend_edge = ecount + ref_lat(issue_multop, rs1, rs2);
          pend_rd   = rd;
          pend_rob  = rob;
        end
      end
    end
  end

  task automatic issue_op(input mult_ops op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [RW-1:0] o);
    @(negedge clk);
    issue_valid  = 1'b1;
    issue_multop = op;
    rs1 = a;
    rs2 = b;
    rd  = r;
    rob = o;
  endtask

  task automatic expect_result(input string name, input logic [31:0] exp, input int lat,
                               input logic [4:0] r, input logic [RW-1:0] o);
    int seen;
    seen = 0;
    for (int i = 1; i <= 60 && seen == 0; i++) begin
      @(negedge clk);
      issue_valid = 1'b0;
      #3;
      if (mul_valid) seen = i;
    end
    if (seen == 0) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_lat"}, seen, lat);
      chk({name, "_data"}, mul_data, exp);
      chk({name, "_rd"}, mul_rd_addr, r);
      chk({name, "_rob"}, mul_rob_idx, o);
    end
  endtask

  typedef struct {
    mult_ops     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{MOP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 3},
      '{MOP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3},
      '{MOP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3},
      '{MOP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 3},
      '{MOP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 3},
      '{MOP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 3},
      '{MOP_DIV,    32'd100,      32'd7,        32'd14,       33},
      '{MOP_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33},
      '{MOP_DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33},
      '{MOP_DIVU,   32'hFFFFFFFF, 32'd10,       32'h19999999, 33},
      '{MOP_REMU,   32'd100,      32'd7,        32'd2,        33},
      '{MOP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33},
      '{MOP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33},
      '{MOP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1},
      '{MOP_REMU,   32'd5,        32'd0,        32'd5,        1},
      '{MOP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
      '{MOP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
      '{MOP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1}
    };

    // Pin the reference model against hand-computed values.
    chk("model_mul", ref_result(MOP_MUL, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("model_mulh", ref_result(MOP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h0);
    chk("model_rem", ref_result(MOP_REM, 32'hFFFFFF9C, 32'd7), 32'hFFFFFFFE);
    chk("model_divz_lat", ref_lat(MOP_DIVU, 32'd5, 32'd0), 1);

    repeat (3) @(negedge clk);
    #3;
    chk("reset_valid", mul_valid, 0);
    chk("reset_data", mul_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("reset_release_ready", issue_ready, 1);

    for (int i = 0; i < 18; i++) begin
      issue_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), RW'(i + 4));
      expect_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat, 5'(i + 1), RW'(i + 4));
    end

    // Issue while busy is ignored.
    issue_op(MOP_DIVU, 32'd1000, 32'd10, 5'd5, RW'(6));
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_multop = MOP_MUL;
    rs1 = 32'd2;
    rs2 = 32'd2;
    rd  = 5'd30;
    rob = RW'(30);
    #3;
    chk("busy_ready_low", issue_ready, 0);
    expect_result("busy_ignore", 32'd100, 31, 5'd5, RW'(6));

    // Flush mid-divide, then a multiply in the first idle cycle.
    issue_op(MOP_DIV, 32'd100, 32'd7, 5'd1, RW'(2));
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      issue_valid = 1'b0;
      flush = (i == 10);
      #3;
      chk("flush_no_valid", mul_valid, 0);
    end
    @(negedge clk);
    flush = 1'b0;
    issue_valid = 1'b1;
    issue_multop = MOP_MUL;
    rs1 = 32'd3;
    rs2 = 32'd3;
    rd  = 5'd9;
    rob = RW'(9);
    #3;
    chk("flush_ready_next", issue_ready, 1);
    expect_result("mul_after_flush", 32'd9, 3, 5'd9, RW'(9));
    repeat (30) @(negedge clk);

    // Reset in the middle of a divide.
    issue_op(MOP_DIV, 32'd100, 32'd7, 5'd1, RW'(1));
    repeat (4) begin
      @(negedge clk);
      issue_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_mid_valid", mul_valid, 0);
    chk("rst_mid_data", mul_data, 0);
    chk("rst_mid_rob", mul_rob_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #3;
    chk("rst_mid_ready", issue_ready, 1);
    repeat (40) @(negedge clk);

    // Flush and issue in the same cycle: nothing accepted.
    @(negedge clk);
    flush = 1'b1;
    issue_valid = 1'b1;
    issue_multop = MOP_MUL;
    rs1 = 32'd5;
    rs2 = 32'd5;
    #3;
    chk("flush_issue_valid", mul_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    issue_valid = 1'b0;
    #3;
    chk("flush_issue_ready", issue_ready, 1);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
